// File: rtl/bus_arbiter.sv
// Two-port CPU memory bus arbiter: instruction fetch (I) vs data load/store (D).
// Latency: request to mem_start 1 cycle; done/q routed back combinationally with mem_done.
// Backpressure: a losing requester stays pending until the next IDLE cycle; no abort once granted.
module bus_arbiter #(
  parameter int RR_MODE = 0,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_we,
  input  logic              i_start,
  output logic [DATA_W-1:0] i_q,
  output logic              i_done,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_data,
  input  logic              d_we,
  input  logic              d_start,
  output logic [DATA_W-1:0] d_q,
  output logic              d_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  output logic              mem_start,
  input  logic [DATA_W-1:0] mem_q,
  input  logic              mem_done,
  output logic [1:0]        grant,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_take_i;
  logic                w_take_d;
  logic                r_last_d;   // 1 when D was granted most recently (round-robin pointer)
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic                r_we;
  logic                r_start;
  logic [1:0]          r_grant;
  logic                w_i_done;
  logic                w_d_done;

  // Next-state and winner selection; grants are only decided from IDLE
  always_comb begin
    w_next   = r_state;
    w_take_i = 1'b0;
    w_take_d = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start && d_start) begin
          if (RR_MODE != 0 && r_last_d) begin
            w_take_i = 1'b1;
          end else begin
            w_take_d = 1'b1;
          end
        end else if (i_start) begin
          w_take_i = 1'b1;
        end else if (d_start) begin
          w_take_d = 1'b1;
        end
        if (w_take_i) begin
          w_next = BUSY_I;
        end else if (w_take_d) begin
          w_next = BUSY_D;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_done) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Downstream request registers: captured on grant, frozen while busy, released on mem_done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr   <= '0;
      r_data   <= '0;
      r_we     <= 1'b0;
      r_start  <= 1'b0;
      r_grant  <= 2'b00;
      r_last_d <= 1'b0;
    end else if (w_take_i) begin
      r_addr  <= i_addr;
      r_data  <= i_data;
      r_we    <= i_we;
      r_start <= 1'b1;
      r_grant <= 2'b01;
      if (RR_MODE != 0) begin
        r_last_d <= 1'b0;
      end
    end else if (w_take_d) begin
      r_addr  <= d_addr;
      r_data  <= d_data;
      r_we    <= d_we;
      r_start <= 1'b1;
      r_grant <= 2'b10;
      if (RR_MODE != 0) begin
        r_last_d <= 1'b1;
      end
    end else if (r_state != IDLE && mem_done) begin
      r_start <= 1'b0;
      r_grant <= 2'b00;
    end
  end

  // Completion routing: grant is 00 in IDLE, so a stale mem_done reaches nobody
  assign w_i_done  = mem_done && r_grant[0];
  assign w_d_done  = mem_done && r_grant[1];
  assign i_done    = w_i_done;
  assign d_done    = w_d_done;
  assign i_q       = w_i_done ? mem_q : '0;
  assign d_q       = w_d_done ? mem_q : '0;

  assign mem_addr  = r_addr;
  assign mem_data  = r_data;
  assign mem_we    = r_we;
  assign mem_start = r_start;
  assign grant     = r_grant;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: instance 0 is fixed priority, instance 1 is round-robin.
// A transaction-level model predicts owner/captured request/completion every cycle.
// Directed scenarios pin the model with literal values, then random traffic runs on both.
module tb_bus_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] ia   [2];
  logic [31:0] idat [2];
  logic        iwe  [2];
  logic        is   [2];
  logic [31:0] iq   [2];
  logic        idn  [2];
  logic [31:0] da   [2];
  logic [31:0] ddat [2];
  logic        dwe  [2];
  logic        ds   [2];
  logic [31:0] dq   [2];
  logic        ddn  [2];
  logic [31:0] maddr[2];
  logic [31:0] mdat [2];
  logic        mwe  [2];
  logic        ms   [2];
  logic [31:0] mq   [2];
  logic        md   [2];
  logic [1:0]  gnt  [2];
  logic        bsy  [2];

  int checks   = 0;
  int failures = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    bus_arbiter #(.RR_MODE(g), .ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .reset(rst),
      .i_addr(ia[g]), .i_data(idat[g]), .i_we(iwe[g]), .i_start(is[g]),
      .i_q(iq[g]), .i_done(idn[g]),
      .d_addr(da[g]), .d_data(ddat[g]), .d_we(dwe[g]), .d_start(ds[g]),
      .d_q(dq[g]), .d_done(ddn[g]),
      .mem_addr(maddr[g]), .mem_data(mdat[g]), .mem_we(mwe[g]), .mem_start(ms[g]),
      .mem_q(mq[g]), .mem_done(md[g]),
      .grant(gnt[g]), .busy(bsy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: owner is 0 = nobody, 1 = I, 2 = D; last is the most recently granted port
  int          own   [2];
  int          last  [2];
  logic [31:0] cap_a [2];
  logic [31:0] cap_d [2];
  logic        cap_w [2];

  always @(posedge clk or posedge rst) begin
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        own[m] = 0; last[m] = 1; cap_a[m] = 0; cap_d[m] = 0; cap_w[m] = 0;
      end else if (own[m] != 0) begin
        if (md[m]) own[m] = 0;
      end else begin
        int win;
        win = 0;
        if (is[m] && ds[m]) win = (m == 1) ? 3 - last[m] : 2;
        else if (is[m])     win = 1;
        else if (ds[m])     win = 2;
        if (win == 1) begin
          cap_a[m] = ia[m]; cap_d[m] = idat[m]; cap_w[m] = iwe[m];
        end else if (win == 2) begin
          cap_a[m] = da[m]; cap_d[m] = ddat[m]; cap_w[m] = dwe[m];
        end
        if (win != 0) begin
          own[m] = win;
          last[m] = win;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      logic e_id, e_dd;
      e_id = md[m] && own[m] == 1;
      e_dd = md[m] && own[m] == 2;
      chk($sformatf("m%0d grant", m), 32'(gnt[m]), (own[m] == 1) ? 32'h1 : (own[m] == 2) ? 32'h2 : 32'h0);
      chk($sformatf("m%0d mem_start", m), 32'(ms[m]), 32'(own[m] != 0));
      chk($sformatf("m%0d busy", m), 32'(bsy[m]), 32'(own[m] != 0));
      chk($sformatf("m%0d mem_addr", m), maddr[m], cap_a[m]);
      chk($sformatf("m%0d mem_data", m), mdat[m], cap_d[m]);
      chk($sformatf("m%0d mem_we", m), 32'(mwe[m]), 32'(cap_w[m]));
      chk($sformatf("m%0d i_done", m), 32'(idn[m]), 32'(e_id));
      chk($sformatf("m%0d d_done", m), 32'(ddn[m]), 32'(e_dd));
      chk($sformatf("m%0d i_q", m), iq[m], e_id ? mq[m] : 32'h0);
      chk($sformatf("m%0d d_q", m), dq[m], e_dd ? mq[m] : 32'h0);
    end
  end

  // Random traffic: requesters obey the handshake (occasionally dropping), memory answers after 0-3 cycles
  bit   rnd_en = 0;
  logic sidn [2];
  logic sddn [2];
  int   cnt  [2];

  task automatic drive_random();
    for (int m = 0; m < 2; m++) begin
      if (is[m] && sidn[m])           is[m] = 1'($urandom % 2);
      else if (!is[m])                is[m] = ($urandom % 3) == 0;
      else if ($urandom % 32 == 0)    is[m] = 1'b0;
      if (!is[m] || $urandom % 4 == 0) begin
        ia[m] = $urandom; idat[m] = $urandom; iwe[m] = 1'($urandom % 2);
      end
      if (ds[m] && sddn[m])           ds[m] = 1'($urandom % 2);
      else if (!ds[m])                ds[m] = ($urandom % 3) == 0;
      else if ($urandom % 32 == 0)    ds[m] = 1'b0;
      if (!ds[m] || $urandom % 4 == 0) begin
        da[m] = $urandom; ddat[m] = $urandom; dwe[m] = 1'($urandom % 2);
      end
      mq[m] = $urandom;
      md[m] = 1'b0;
      if (ms[m]) begin
        if (cnt[m] == 0) begin
          md[m] = 1'b1;
          cnt[m] = $urandom % 4;
        end else begin
          cnt[m]--;
        end
      end else begin
        md[m] = ($urandom % 16) == 0;
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      sidn[m] = idn[m];
      sddn[m] = ddn[m];
    end
    @(posedge clk);
    #1;
    if (rnd_en) drive_random();
  endtask

  logic [1:0] rr_exp [4];

  initial begin
    rr_exp = '{2'b10, 2'b01, 2'b10, 2'b01};
    rst = 1'b1;
    for (int m = 0; m < 2; m++) begin
      ia[m] = 0; idat[m] = 0; iwe[m] = 0; is[m] = 0;
      da[m] = 0; ddat[m] = 0; dwe[m] = 0; ds[m] = 0;
      mq[m] = 0; md[m] = 0; cnt[m] = 0; sidn[m] = 0; sddn[m] = 0;
    end
    cyc();
    chk("reset grant", 32'(gnt[0]), 32'h0);
    chk("reset mem_start", 32'(ms[1]), 32'h0);
    cyc();
    rst = 1'b0;

    // Reset while in BUSY_D, then a stale mem_done in IDLE
    ds[0] = 1; da[0] = 32'h200; dwe[0] = 1; ddat[0] = 32'h55;
    cyc();
    chk("pre-reset grant", 32'(gnt[0]), 32'h2);
    rst = 1'b1; ds[0] = 0;
    #1;
    chk("mid reset grant", 32'(gnt[0]), 32'h0);
    chk("mid reset mem_start", 32'(ms[0]), 32'h0);
    #2;
    rst = 1'b0;
    cyc();
    md[0] = 1; mq[0] = 32'h1234;
    #1;
    chk("stale i_done", 32'(idn[0]), 32'h0);
    chk("stale d_done", 32'(ddn[0]), 32'h0);
    cyc();
    md[0] = 0;
    chk("stale grant", 32'(gnt[0]), 32'h0);

    // Single fetch, mem_done 3 cycles after mem_start
    is[0] = 1; ia[0] = 32'h100; iwe[0] = 0;
    cyc();
    chk("fetch mem_addr", maddr[0], 32'h100);
    chk("fetch mem_we", 32'(mwe[0]), 32'h0);
    chk("fetch grant", 32'(gnt[0]), 32'h1);
    cyc();
    cyc();
    cyc();
    md[0] = 1; mq[0] = 32'hDEADBEEF;
    #1;
    chk("fetch i_done", 32'(idn[0]), 32'h1);
    chk("fetch i_q", iq[0], 32'hDEADBEEF);
    chk("fetch d_done", 32'(ddn[0]), 32'h0);
    cyc();
    md[0] = 0; is[0] = 0;
    chk("fetch grant after", 32'(gnt[0]), 32'h0);

    // Tie in fixed priority: D first, then I
    ds[0] = 1; da[0] = 32'h200; dwe[0] = 1; ddat[0] = 32'h55;
    is[0] = 1; ia[0] = 32'h300; iwe[0] = 0;
    cyc();
    chk("tie0 first grant", 32'(gnt[0]), 32'h2);
    chk("tie0 mem_we", 32'(mwe[0]), 32'h1);
    chk("tie0 mem_data", mdat[0], 32'h55);
    md[0] = 1;
    cyc();
    md[0] = 0; ds[0] = 0;
    chk("tie0 idle gap", 32'(gnt[0]), 32'h0);
    cyc();
    chk("tie0 second grant", 32'(gnt[0]), 32'h1);
    chk("tie0 second addr", maddr[0], 32'h300);
    md[0] = 1;
    cyc();
    md[0] = 0; is[0] = 0;

    // Tie in round-robin, both held for 4 transactions
    is[1] = 1; ia[1] = 32'hA0; ds[1] = 1; da[1] = 32'hB0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk($sformatf("rr grant %0d", k), 32'(gnt[1]), 32'(rr_exp[k]));
      md[1] = 1;
      cyc();
      md[1] = 0;
    end
    is[1] = 0; ds[1] = 0;

    // Requester drops start one cycle after grant
    is[0] = 1; ia[0] = 32'h440;
    cyc();
    chk("drop grant", 32'(gnt[0]), 32'h1);
    cyc();
    is[0] = 0; ia[0] = 32'h999;
    cyc();
    chk("drop mem_start", 32'(ms[0]), 32'h1);
    chk("drop mem_addr", maddr[0], 32'h440);
    md[0] = 1;
    #1;
    chk("drop i_done", 32'(idn[0]), 32'h1);
    cyc();
    md[0] = 0;
    chk("drop mem_start after", 32'(ms[0]), 32'h0);

    // Input change during BUSY_D
    ds[0] = 1; da[0] = 32'h600;
    cyc();
    chk("busy capture", maddr[0], 32'h600);
    da[0] = 32'h7FF;
    cyc();
    chk("busy frozen", maddr[0], 32'h600);
    md[0] = 1;
    cyc();
    md[0] = 0; ds[0] = 0;
    cyc();

    // Random traffic on both instances
    rnd_en = 1;
    repeat (4000) cyc();
    rnd_en = 0;
    for (int m = 0; m < 2; m++) begin
      is[m] = 0; ds[m] = 0; md[m] = 0;
    end
    repeat (3) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
